// File: rtl/crc10_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// crc10_framer
//
// Frame controller placed in front of a 32-bit-per-clock CRC-10 engine.
// Payload words are forwarded from the input stream to a registered output
// stream while being fed to the engine. After the last payload word of a
// frame the block waits CRC_LAT cycles for the engine result and appends one
// trailer word carrying the CRC. The engine is cleared for one cycle before
// every frame.
//
// Parameters:
//   MAX_WORDS  maximum payload words per frame (1..65535); a frame reaching
//              this length without In_Last is cut and Frame_Err pulses
//   CRC_LAT    engine latency from the last Crc_En edge to a valid Crc_In
//              (1..15)
//
// Configuration macro:
//   CRC10_FRAMER_LEN_EN  when defined, trailer bits [31:16] carry the payload
//                        word count and bit 10 the truncation flag; when
//                        undefined, trailer bits [31:10] are zero.
//
// Ports:
//   Clock, Reset          clock (rising edge), asynchronous active-high reset
//   In_Data/Valid/Last    source stream; In_Ready back-pressure to source
//   Out_Data/Valid/Last   sink stream (registered); Out_Ready from sink
//   Crc_Data, Crc_En      engine data and enable (combinational)
//   Crc_Clr               engine clear (registered)
//   Crc_In                engine CRC result
//   Frame_Err             one-cycle pulse on a truncated frame
// -----------------------------------------------------------------------------
module crc10_framer #(
  parameter int MAX_WORDS = 256,
  parameter int CRC_LAT   = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] In_Data,
  input  logic        In_Valid,
  input  logic        In_Last,
  output logic        In_Ready,
  output logic [31:0] Out_Data,
  output logic        Out_Valid,
  output logic        Out_Last,
  input  logic        Out_Ready,
  output logic [31:0] Crc_Data,
  output logic        Crc_En,
  output logic        Crc_Clr,
  input  logic [9:0]  Crc_In,
  output logic        Frame_Err
);

`ifdef CRC10_FRAMER_LEN_EN
  // Count is reported in the trailer, so it needs the full 16-bit field.
  localparam int CNT_W = 16;
`else
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
`endif
  localparam int WAIT_W = 4;
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [WAIT_W-1:0] LAT_LD  = WAIT_W'(CRC_LAT);

  typedef enum logic [1:0] {
    S_CLEAR    = 2'd0,
    S_PAYLOAD  = 2'd1,
    S_WAIT_CRC = 2'd2,
    S_TRAILER  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_n;

  logic [31:0]        r_out_data_p1;
  logic               r_out_vld_p1;
  logic               r_out_last_p1;
  logic               r_crc_clr;
  logic               r_frame_err;
  logic [CNT_W-1:0]   r_count;
  logic [WAIT_W-1:0]  r_wait;
`ifdef CRC10_FRAMER_LEN_EN
  logic               r_trunc;
`endif

  logic               w_out_free;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_at_max;
  logic               w_frame_end;
  logic               w_trunc;
  logic               w_trailer_go;
  logic [CNT_W-1:0]   w_count_inc;
  logic [WAIT_W-1:0]  w_wait_dec;
  logic [31:0]        w_trailer;

`ifdef CRC10_FRAMER_LEN_EN
  function automatic logic [31:0] f_trailer(input logic [9:0]  crc,
                                            input logic [15:0] cnt,
                                            input logic        trunc);
    return {cnt, 5'b0, trunc, crc};
  endfunction
`else
  function automatic logic [31:0] f_trailer(input logic [9:0] crc);
    return {22'b0, crc};
  endfunction
`endif

  // The output register can take a new word when empty or being drained.
  assign w_out_free  = !r_out_vld_p1 | Out_Ready;
  assign w_count_inc = r_count + 1'b1;
  assign w_at_max    = (w_count_inc == MAX_CNT);
  assign w_wait_dec  = r_wait - 1'b1;

`ifdef CRC10_FRAMER_LEN_EN
  assign w_trailer = f_trailer(Crc_In, r_count, r_trunc);
`else
  assign w_trailer = f_trailer(Crc_In);
`endif

  always_comb begin
    w_state_n    = r_state;
    w_in_ready   = 1'b0;
    w_frame_end  = 1'b0;
    w_trunc      = 1'b0;
    w_trailer_go = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_state_n = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_in_ready = w_out_free;
        if (In_Valid && w_out_free && (In_Last || w_at_max)) begin
          w_frame_end = 1'b1;
          w_trunc     = !In_Last;
          w_state_n   = S_WAIT_CRC;
        end
      end
      S_WAIT_CRC: begin
        // Leave after CRC_LAT cycles so Crc_In is sampled at the edge
        // CRC_LAT+1 after the last enable.
        if (w_wait_dec == '0) begin
          w_state_n = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (w_out_free) begin
          w_trailer_go = 1'b1;
          w_state_n    = S_CLEAR;
        end
      end
      default: begin
        w_state_n = S_CLEAR;
      end
    endcase
  end

  assign w_accept = In_Valid & w_in_ready;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Engine clear mirrors the CLEAR state one-for-one, so it can never
  // coincide with an accepted word.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_crc_clr   <= 1'b1;
      r_frame_err <= 1'b0;
    end else begin
      r_crc_clr   <= (w_state_n == S_CLEAR);
      r_frame_err <= w_trunc;
    end
  end

  // Counters: word count holds through WAIT_CRC/TRAILER for the trailer.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_wait  <= '0;
    end else begin
      if (w_trailer_go) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= w_count_inc;
      end
      if (w_frame_end) begin
        r_wait <= LAT_LD;
      end else if (r_state == S_WAIT_CRC) begin
        r_wait <= w_wait_dec;
      end
    end
  end

`ifdef CRC10_FRAMER_LEN_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_trunc <= 1'b0;
    end else if (w_trunc) begin
      r_trunc <= 1'b1;
    end else if (w_trailer_go) begin
      r_trunc <= 1'b0;
    end
  end
`endif

  // ---- stage p1: output register (payload or trailer) ----
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_out_data_p1 <= '0;
      r_out_vld_p1  <= 1'b0;
      r_out_last_p1 <= 1'b0;
    end else if (w_accept) begin
      r_out_data_p1 <= In_Data;
      r_out_vld_p1  <= 1'b1;
      r_out_last_p1 <= 1'b0;
    end else if (w_trailer_go) begin
      r_out_data_p1 <= w_trailer;
      r_out_vld_p1  <= 1'b1;
      r_out_last_p1 <= 1'b1;
    end else if (Out_Ready) begin
      r_out_vld_p1  <= 1'b0;
      r_out_last_p1 <= 1'b0;
    end
  end

  assign In_Ready  = w_in_ready;
  assign Out_Data  = r_out_data_p1;
  assign Out_Valid = r_out_vld_p1;
  assign Out_Last  = r_out_last_p1;
  assign Crc_Data  = In_Data;
  assign Crc_En    = w_accept;
  assign Crc_Clr   = r_crc_clr;
  assign Frame_Err = r_frame_err;

endmodule

// File: tb/tb_crc10_framer.sv
`timescale 1ns/1ps
// Testbench for crc10_framer: two instances with different MAX_WORDS/CRC_LAT,
// one active at a time, sharing a behavioural engine model and a scoreboard.
module tb_crc10_framer;

  localparam int MW0 = 4, LAT0 = 1;
  localparam int MW1 = 7, LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b0;
  logic        sel      = 1'b0;
  logic [31:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_last  = 1'b0;
  logic        stall    = 1'b0;
  logic        rdy_mode = 1'b0;
  logic        rnd_rdy  = 1'b1;
  logic [9:0]  crc_in;
  wire         out_ready = !stall && (!rdy_mode || rnd_rdy);

  logic        ir0, ov0, ol0, clr0, en0, fe0, ir1, ov1, ol1, clr1, en1, fe1;
  logic [31:0] od0, cd0, od1, cd1;

  crc10_framer #(.MAX_WORDS(MW0), .CRC_LAT(LAT0)) u_dut0 (
    .Clock(clk), .Reset(rst), .In_Data(in_data), .In_Valid(in_valid && !sel),
    .In_Last(in_last), .In_Ready(ir0), .Out_Data(od0), .Out_Valid(ov0),
    .Out_Last(ol0), .Out_Ready(out_ready || sel), .Crc_Data(cd0), .Crc_En(en0),
    .Crc_Clr(clr0), .Crc_In(crc_in), .Frame_Err(fe0));

  crc10_framer #(.MAX_WORDS(MW1), .CRC_LAT(LAT1)) u_dut1 (
    .Clock(clk), .Reset(rst), .In_Data(in_data), .In_Valid(in_valid && sel),
    .In_Last(in_last), .In_Ready(ir1), .Out_Data(od1), .Out_Valid(ov1),
    .Out_Last(ol1), .Out_Ready(out_ready || !sel), .Crc_Data(cd1), .Crc_En(en1),
    .Crc_Clr(clr1), .Crc_In(crc_in), .Frame_Err(fe1));

  wire        in_ready = sel ? ir1 : ir0;
  wire        ov       = sel ? ov1 : ov0;
  wire        ol       = sel ? ol1 : ol0;
  wire [31:0] od       = sel ? od1 : od0;
  wire        crc_clr  = sel ? clr1 : clr0;
  wire        crc_en   = sel ? en1 : en0;
  wire [31:0] crc_data = sel ? cd1 : cd0;
  wire        fe       = sel ? fe1 : fe0;
  int lat_cur;
  assign lat_cur = sel ? LAT1 : LAT0;

  int n_vec = 0, n_err = 0, cyc = 0;
  int acc_cyc = 0, acc_cnt = 0, clr_cnt = 0, n_out = 0, fe_cnt = 0;
  int trunc_cyc = -100;
  logic [32:0] exp_q[$];
  logic [31:0] frame_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: folding checksum, cleared by Crc_Clr; result is only valid
  // once CRC_LAT edges have passed since the last enable, garbage before.
  function automatic logic [9:0] eng_step(input logic [9:0] a, input logic [31:0] d);
    return {a[8:0], a[9]} ^ d[9:0] ^ d[19:10] ^ d[29:20] ^ {8'b0, d[31:30]};
  endfunction

  logic [9:0]  acc  = '0;
  logic [9:0]  garb = 10'h1;
  logic        en_s = 1'b0, clr_s = 1'b0;
  logic [31:0] d_s  = '0;
  int          since = 15;
  always @(negedge clk) begin
    en_s  <= crc_en;
    clr_s <= crc_clr;
    d_s   <= crc_data;
  end
  always @(posedge clk) begin
    if (clr_s) acc <= '0;
    else if (en_s) acc <= eng_step(acc, d_s);
    since <= en_s ? 0 : ((since < 15) ? since + 1 : since);
    garb  <= 10'($urandom_range(1, 1023));
  end
  assign crc_in = (since >= lat_cur) ? acc : (acc ^ garb);

  // Reference: CRC of a whole frame from its word list.
  function automatic logic [9:0] ref_crc(input logic [31:0] w[$]);
    logic [9:0] c;
    c = '0;
    for (int i = 0; i < w.size(); i++) c = eng_step(c, w[i]);
    return c;
  endfunction

  function automatic int cur_maxw();
    return sel ? MW1 : MW0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %08h required %08h", nm, got, req);
    end
  endtask

  task automatic model_accept(input logic [31:0] d, input logic last);
    logic [9:0]  c;
    logic [31:0] tw;
    logic        tr;
    exp_q.push_back({1'b0, d});
    frame_q.push_back(d);
    if (last || frame_q.size() == cur_maxw()) begin
      tr = !last;
      if (tr) trunc_cyc = cyc;
      c = ref_crc(frame_q);
`ifdef CRC10_FRAMER_LEN_EN
      tw = {16'(frame_q.size()), 5'b0, tr, c};
`else
      tw = {22'b0, c};
`endif
      exp_q.push_back({1'b1, tw});
      frame_q.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic last);
    bit ok;
    ok = 0;
    in_data = d; in_valid = 1'b1; in_last = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: got no In_Ready in 200 cycles required accept of %08h", d);
    end else begin
      model_accept(d, last);
      acc_cyc = cyc;
      acc_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = $urandom;
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send($urandom, (i == n - 1));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input logic new_sel);
    rst = 1'b1;
    sel = new_sel;
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.delete(); frame_q.delete(); trunc_cyc = -100;
    #1;
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_out_last",  32'(ol), 32'd0);
    chk("rst_out_data",  od, 32'd0);
    chk("rst_crc_clr",   32'(crc_clr), 32'd1);
    chk("rst_frame_err", 32'(fe), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_crc_clr_first", 32'(crc_clr), 32'd1);
    chk("rel_in_ready_first", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_crc_clr_second", 32'(crc_clr), 32'd0);
    chk("rel_in_ready_second", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Back-to-back 3-word and 2-word frames with the sink always ready.
  task automatic back_to_back();
    int f1_last, c1, o1;
    o1 = n_out;
    send_frame(3, 0);
    f1_last = acc_cyc;
    c1 = clr_cnt;
    send($urandom, 1'b0);
    chk("b2b_gap_cycles", 32'(acc_cyc - f1_last), 32'(lat_cur + 3));
    chk("b2b_clr_pulses", 32'(clr_cnt - c1), 32'd1);
    send($urandom, 1'b1);
    drain();
    chk("b2b_out_words", 32'(n_out - o1), 32'd7);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (crc_clr === 1'b1) clr_cnt++;
      if (fe === 1'b1) fe_cnt++;
      n_vec++;
      if ((crc_clr & crc_en) !== 1'b0) begin
        n_err++;
        $display("FAIL clr_en_overlap: got clr=%0b en=%0b required not both high", crc_clr, crc_en);
      end
      n_vec++;
      if (fe !== (cyc == trunc_cyc + 1)) begin
        n_err++;
        $display("FAIL frame_err: got %0b required %0b at cycle %0d", fe, (cyc == trunc_cyc + 1), cyc);
      end
      if (ov === 1'b1 && out_ready) begin
        n_out++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got last=%0b data=%08h required no output", ol, od);
        end else begin
          e = exp_q.pop_front();
          if ({ol, od} !== e) begin
            n_err++;
            $display("FAIL out_word: got last=%0b data=%08h required last=%0b data=%08h",
                     ol, od, e[32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, f0;
    logic [31:0] held;
    #1;
    do_reset(1'b0);

    // Single word: data 1, engine result 0x001.
    send(32'h0000_0001, 1'b1);
    drain();

    back_to_back();

    // Sink stall of 5 cycles in the middle of a 4-word frame.
    base = acc_cnt;
    fork
      send_frame(4, 0);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (acc_cnt >= base + 2) break;
        end
        @(posedge clk); #1;
        stall = 1'b1;
        held = od;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(ov), 32'd1);
          chk("stall_out_hold", od, held);
        end
        @(posedge clk); #1;
        stall = 1'b0;
      end
    join
    drain();

    // Truncation: 6 words, In_Last only on the sixth, MAX_WORDS = 4.
    f0 = fe_cnt;
    send_frame(6, 0);
    drain();
    chk("trunc_err_pulses", 32'(fe_cnt - f0), 32'd1);

    // Reset after 2 of 5 words: partial frame discarded, no trailer.
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    do_reset(1'b0);
    send_frame(3, 0);
    drain();

    // Randomized frames with random sink back-pressure and source gaps.
    rdy_mode = 1'b1;
    for (int f = 0; f < 40; f++) send_frame($urandom_range(1, MW0 + 2), 1);
    drain();
    rdy_mode = 1'b0;
    drain();

    // Second instance: CRC_LAT = 3, MAX_WORDS = 7.
    do_reset(1'b1);
    send(32'h0000_0001, 1'b1);
    drain();
    back_to_back();
    rdy_mode = 1'b1;
    for (int f = 0; f < 30; f++) send_frame($urandom_range(1, MW1 + 2), 1);
    drain();
    rdy_mode = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
